approx_mul_pipe: RTL and testbench

APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

---
 rtl/approx_mul_pipe_pkg.sv | 10 +
 rtl/approx_mul_pipe_pp_sum.sv | 47 ++++
 rtl/approx_mul_pipe.sv | 97 +++++++++
 tb/tb_approx_mul_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pipe_pkg.sv
// Shared constants for the approximate multiplier pipeline.
package approx_mul_pipe_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Width of the approximate-operation delivery counter.
  localparam int CNT_W = 16;

endpackage

// File: rtl/approx_mul_pipe_pp_sum.sv
// Combinational product generator: exact x*y, or a column-truncated
// partial-product sum with a fixed half-column compensation term.
module approx_pp_sum
  import approx_mul_pipe_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 6
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           mode,
  output logic [2*W-1:0] prod
);

  localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};
  // 2^(K-1) for K > 0, zero for K = 0 (shift left K, then back by one).
  localparam logic [2*W-1:0] COMP = (ONE << K) >> 1;

  logic [2*W-1:0] xe;
  logic [2*W-1:0] ye;
  logic [2*W-1:0] exact_prod;
  logic [2*W-1:0] trunc_sum;

  assign xe = {{W{1'b0}}, x};
  assign ye = {{W{1'b0}}, y};
  assign exact_prod = xe * ye;

  // Sum of partial-product bits in columns K and above, plus compensation.
  // The truncated sum is at most the exact product minus the dropped
  // columns, and COMP <= 2^(W-1), so the result always fits in 2W bits.
  always_comb begin
    trunc_sum = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (((i + j) >= K) && x[i] && y[j]) begin
          trunc_sum = trunc_sum + (ONE << (i + j));
        end
      end
    end
    if ((x != '0) && (y != '0)) begin
      trunc_sum = trunc_sum + COMP;
    end
  end

  assign prod = (mode == MODE_APPROX) ? trunc_sum : exact_prod;

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined exact/approximate unsigned multiplier with valid/ready handshake,
// sideband tag, and a saturating count of delivered approximate operations.
module approx_mul_pipe
  import approx_mul_pipe_pkg::*;
#(
  parameter int W      = 8,
  parameter int K      = 6,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             mode,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   z,
  output logic [TAGW-1:0]  out_tag,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int LAST = STAGES - 1;

  logic                             en;
  logic                             deliver_approx;
  logic [2*W-1:0]                   prod_d;
  logic [STAGES-1:0]                vld_q;
  logic [STAGES-1:0]                mode_q;
  logic [STAGES-1:0][2*W-1:0]       dat_q;
  logic [STAGES-1:0][TAGW-1:0]      tag_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [CNT_W-1:0]                 cnt_d;

  approx_pp_sum #(
    .W (W),
    .K (K)
  ) u_pp_sum (
    .x    (x),
    .y    (y),
    .mode (mode),
    .prod (prod_d)
  );

  // Whole pipe moves together; it only holds when the output is stuck.
  assign en       = ~vld_q[LAST] | out_ready;
  assign in_ready = en;

  // Shift valid/data/tag/mode down the pipe on every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      dat_q  <= '0;
      tag_q  <= '0;
    end else if (en) begin
      vld_q[0]  <= in_valid;
      mode_q[0] <= mode;
      dat_q[0]  <= prod_d;
      tag_q[0]  <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s]  <= vld_q[s-1];
        mode_q[s] <= mode_q[s-1];
        dat_q[s]  <= dat_q[s-1];
        tag_q[s]  <= tag_q[s-1];
      end
    end
  end

  assign deliver_approx = vld_q[LAST] & out_ready & (mode_q[LAST] == MODE_APPROX);

  // Saturating increment on each approximate-mode delivery.
  always_comb begin
    cnt_d = cnt_q;
    if (deliver_approx && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = vld_q[LAST];
  assign z          = dat_q[LAST];
  assign out_tag    = tag_q[LAST];
  assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe (W=8, K=6, STAGES=2, TAGW=4).
module tb_approx_mul_pipe;

  localparam int W      = 8;
  localparam int K      = 6;
  localparam int STAGES = 2;
  localparam int TAGW   = 4;

  typedef struct {
    logic [2*W-1:0]  z;
    logic [TAGW-1:0] tag;
    int              cyc;
    bit              lat;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x;
  logic [W-1:0]    y;
  logic            mode;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  z;
  logic [TAGW-1:0] out_tag;
  logic [15:0]     approx_cnt;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  approx_mul_pipe #(
    .W (W), .K (K), .STAGES (STAGES), .TAGW (TAGW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .mode       (mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z),
    .out_tag    (out_tag),
    .approx_cnt (approx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer one operation; push its expectation when the handshake will occur.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                      input logic [TAGW-1:0] t, input logic [2*W-1:0] ez, input bit lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    x = a; y = b; mode = m; in_tag = t; in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    e.z = ez; e.tag = t; e.cyc = cyc; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for all expected results to be delivered, then settle one cycle.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    #3;
  endtask

  // Monitor: compare every delivered result against the head of the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("z", 32'(z), 32'(e.z));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        if (e.lat) chk("latency", 32'(cyc), 32'(e.cyc + STAGES));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [W-1:0]    sx [10] = '{8'd12, 8'd255, 8'd100, 8'd16, 8'd200, 8'd128, 8'd0, 8'd5, 8'd15, 8'd64};
  logic [W-1:0]    sy [10] = '{8'd13, 8'd1,   8'd3,   8'd16, 8'd200, 8'd128, 8'd55, 8'd0, 8'd17, 8'd2};
  logic [2*W-1:0]  sz [10] = '{16'd156, 16'd224, 16'd300, 16'd288, 16'd40000,
                               16'd16416, 16'd0, 16'd0, 16'd255, 16'd160};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; mode = 1'b0; in_tag = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_approx_cnt", 32'(approx_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Exact corner
    send(8'd255, 8'd255, 1'b0, 4'd1, 16'd65025, 1'b1);
    drain();
    chk("cnt_after_exact", 32'(approx_cnt), 32'd0);

    // Approximate vectors
    send(8'd255, 8'd255, 1'b1, 4'd2, 16'd64736, 1'b1);
    send(8'd3,   8'd3,   1'b1, 4'd3, 16'd32,    1'b1);
    send(8'd0,   8'd200, 1'b1, 4'd4, 16'd0,     1'b1);
    drain();
    chk("cnt_after_approx", 32'(approx_cnt), 32'd3);

    // Back-to-back stream, alternating mode, tags 0..9
    for (int k = 0; k < 10; k++) begin
      send(sx[k], sy[k], k[0], 4'(k), sz[k], 1'b1);
    end
    drain();
    chk("cnt_after_stream", 32'(approx_cnt), 32'd8);

    // Stall with a full pipe
    out_ready = 1'b0;
    send(8'd12,  8'd10,  1'b0, 4'hA, 16'd120,   1'b0);
    send(8'd255, 8'd255, 1'b1, 4'hB, 16'd64736, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_z", 32'(z), 32'd120);
      chk("stall_out_tag", 32'(out_tag), 32'hA);
    end
    out_ready = 1'b1;
    send(8'd9, 8'd9, 1'b0, 4'hC, 16'd81, 1'b0);
    drain();
    chk("cnt_after_stall", 32'(approx_cnt), 32'd9);

    // Reset with operations in flight
    send(8'd1, 8'd2, 1'b0, 4'd3, 16'd2,   1'b0);
    send(8'd3, 8'd4, 1'b1, 4'd4, 16'd32,  1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_approx_cnt", 32'(approx_cnt), 32'd0);
    chk("rst2_z", 32'(z), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(8'd7, 8'd9, 1'b0, 4'd5, 16'd63, 1'b1);
    drain();
    chk("post_rst_cnt", 32'(approx_cnt), 32'd0);

    // Saturation of the approximate counter
    for (int n = 0; n < 65534; n++) begin
      send(8'd1, 8'd1, 1'b1, n[3:0], 16'd32, 1'b1);
    end
    drain();
    chk("cnt_fffe", 32'(approx_cnt), 32'hFFFE);
    for (int n = 0; n < 3; n++) begin
      send(8'd2, 8'd128, 1'b1, 4'(n), 16'd288, 1'b1);
      drain();
      chk("cnt_sat", 32'(approx_cnt), 32'hFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
